// File: rtl/rom_fetch_sequencer.sv
// ============================================================================
// rom_fetch_sequencer
// ----------------------------------------------------------------------------
// Instruction-fetch controller placed between a combinational 4-bit-opcode
// program ROM and the CPU execute unit.
//
// The block owns the program counter. It drives the ROM address straight from
// the pc register and registers each returned opcode. It presents that opcode
// to execute over a valid/ready handshake. It also handles skip requests
// coming back from execute (SNZ A / SNZ S outcomes), detects the end of the
// program and halts.
//
// Parameters
//   ADDR_WIDTH   : width of pc / rom_addr.
//   LAST_ADDR    : address whose accepted issue ends the program.
//   CLR_HALT_RUN : number of consecutive accepted CLR (4'b0111) opcodes that
//                  forces a halt; 0 disables the check.
//
// Ports
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   start        in   level; starts execution from address 0 (IDLE / HALT only)
//   rom_addr     out  ROM address, equal to pc
//   rom_data     in   opcode at rom_addr, valid in the same cycle
//   instr        out  registered opcode under issue
//   instr_valid  out  instr is valid
//   instr_ready  in   execute accepts instr this cycle
//   skip_req     in   one-cycle pulse: discard the instruction after this one
//   step         in   (FETCH_SINGLE_STEP_EN only) allows one fetch or skip
//   pc           out  current fetch address
//   halted       out  sequencer is in HALT
//   busy         out  sequencer is in FETCH or ISSUE
//
// Build option
//   FETCH_SINGLE_STEP_EN : when defined, adds the 'step' input. FETCH then
//                          advances only in cycles where step=1. When the
//                          macro is undefined, FETCH advances every cycle.
// ============================================================================
module rom_fetch_sequencer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LAST_ADDR    = 255,
  parameter int CLR_HALT_RUN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [3:0]            rom_data,
  output logic [3:0]            instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  skip_req,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  busy
);

  localparam logic [3:0] OP_CLR = 4'b0111;

  // The run counter only needs to reach CLR_HALT_RUN. It is kept at least
  // one bit wide so the design stays legal when the check is disabled.
  localparam int CW = (CLR_HALT_RUN > 0) ? $clog2(CLR_HALT_RUN + 1) : 1;
  localparam logic [CW-1:0]         CLR_LIMIT = CW'(CLR_HALT_RUN);
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   fetch_addr;   // address of the opcode held in instr
  logic                    skip_pending;
  logic [CW-1:0]           clr_run;

  logic [CW-1:0]           clr_run_next;
  logic                    halt_now;
  logic                    fetch_go;

`ifdef FETCH_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // The ROM is combinational, so its address is simply the pc register.
  assign rom_addr = pc;

  // Status flags are decoded from the state register. They therefore follow
  // the asynchronous reset immediately, and they can never both be high.
  assign halted = (state == S_HALT);
  assign busy   = (state == S_FETCH) || (state == S_ISSUE);

  // Value the CLR run counter takes if the instruction under issue is
  // accepted this cycle. The halt decision uses this updated value.
  // NOTE: every signal driven in always_comb gets a default at the top of the
  // block; without it, a missed branch would infer a latch.
  always_comb begin
    clr_run_next = '0;
    if (instr == OP_CLR) begin
      clr_run_next = (clr_run == CLR_LIMIT) ? clr_run : clr_run + CW'(1);
    end
  end

  always_comb begin
    halt_now = 1'b0;
    if (fetch_addr == LAST) begin
      halt_now = 1'b1;
    end else if ((CLR_HALT_RUN != 0) && (clr_run_next == CLR_LIMIT)) begin
      halt_now = 1'b1;
    end
  end

  // Single sequential process: the FSM and all of its registered outputs.
  // NOTE: state registers use non-blocking assignments. Every branch then
  // reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is a small control flop, so all of them
      // are reset. There is no storage array that would need to stay
      // unreset.
      state        <= S_IDLE;
      pc           <= '0;
      instr        <= OP_CLR;
      instr_valid  <= 1'b0;
      fetch_addr   <= '0;
      skip_pending <= 1'b0;
      clr_run      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_FETCH;
            pc           <= '0;
            skip_pending <= 1'b0;
            clr_run      <= '0;
          end
        end

        S_FETCH: begin
          if (fetch_go) begin
            pc <= pc + ONE;
            if (skip_pending) begin
              // Discard this opcode. A skip_req arriving now is absorbed,
              // because only one instruction is ever skipped per request.
              skip_pending <= 1'b0;
            end else begin
              instr        <= rom_data;
              fetch_addr   <= pc;
              instr_valid  <= 1'b1;
              skip_pending <= skip_req;
              state        <= S_ISSUE;
            end
          end else if (skip_req) begin
            skip_pending <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (skip_req) begin
            skip_pending <= 1'b1;
          end
          if (instr_ready) begin
            instr_valid <= 1'b0;
            clr_run     <= clr_run_next;
            if (halt_now) begin
              // A skip that lands on the halting handshake has nothing left
              // to skip, so it is dropped.
              state        <= S_HALT;
              skip_pending <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        S_HALT: begin
          if (start) begin
            state        <= S_FETCH;
            pc           <= '0;
            skip_pending <= 1'b0;
            clr_run      <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
module tb_rom_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-parameter instance (ADDR_WIDTH=8, LAST_ADDR=255, CLR_HALT_RUN=4).
  logic       b_start, b_ready, b_skip, b_valid, b_halted, b_busy;
  logic [7:0] b_addr, b_pc;
  logic [3:0] b_data, b_instr;
  logic [3:0] b_rom [256];
  assign b_data = b_rom[b_addr];

  rom_fetch_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .rom_addr(b_addr), .rom_data(b_data),
    .instr(b_instr), .instr_valid(b_valid), .instr_ready(b_ready),
    .skip_req(b_skip),
`ifdef FETCH_SINGLE_STEP_EN
    .step(1'b1),
`endif
    .pc(b_pc), .halted(b_halted), .busy(b_busy)
  );

  // Small instance: 4-bit pc wraps, program ends at 15, CLR check disabled.
  logic       s_start, s_ready, s_skip, s_valid, s_halted, s_busy;
  logic [3:0] s_addr, s_pc;
  logic [3:0] s_data, s_instr;
  logic [3:0] s_rom [16];
  assign s_data = s_rom[s_addr];

  rom_fetch_sequencer #(.ADDR_WIDTH(4), .LAST_ADDR(15), .CLR_HALT_RUN(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .rom_addr(s_addr), .rom_data(s_data),
    .instr(s_instr), .instr_valid(s_valid), .instr_ready(s_ready),
    .skip_req(s_skip),
`ifdef FETCH_SINGLE_STEP_EN
    .step(1'b1),
`endif
    .pc(s_pc), .halted(s_halted), .busy(s_busy)
  );

  // Monitor mux: sel picks which instance consume() observes.
  logic       sel;
  logic       m_valid, m_busy;
  logic [3:0] m_instr;
  logic [7:0] m_pc;
  assign m_valid = sel ? s_valid : b_valid;
  assign m_busy  = sel ? s_busy  : b_busy;
  assign m_instr = sel ? s_instr : b_instr;
  assign m_pc    = sel ? {4'b0000, s_pc} : b_pc;

  typedef struct packed {
    logic [3:0] instr;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] i, input logic [7:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a valid issue, compare it with the scoreboard head,
  // and let it be accepted (the caller keeps ready high).
  task automatic consume(input string tag);
    exp_t e;
    int   n;
    check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_instr"}, m_instr, e.instr);
    check({tag, "_pc"},    m_pc,    e.pc);
    check({tag, "_busy"},  m_busy,  1);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   n;

    rst_n = 1'b0; sel = 1'b0;
    b_start = 0; b_ready = 1; b_skip = 0;
    s_start = 0; s_ready = 1; s_skip = 0;
    for (int a = 0; a < 256; a++) b_rom[a] = 4'b0111;
    b_rom[0] = 4'b0000;  b_rom[1] = 4'b0001;  b_rom[2] = 4'b1010;  b_rom[3] = 4'b0010;
    b_rom[4] = 4'b0011;  b_rom[5] = 4'b0100;  b_rom[6] = 4'b0101;  b_rom[7] = 4'b0110;
    b_rom[8] = 4'b1001;  b_rom[9] = 4'b1011;  b_rom[10] = 4'b1000; b_rom[11] = 4'b1100;
    b_rom[12] = 4'b1101; b_rom[13] = 4'b1110; b_rom[14] = 4'b1111;
    for (int a = 0; a < 16; a++) s_rom[a] = 4'b0111;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid",  b_valid,  0);
    check("rst_instr",  b_instr,  4'b0111);
    check("rst_pc",     b_pc,     0);
    check("rst_halted", b_halted, 0);
    check("rst_busy",   b_busy,   0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", b_busy, 0);

    // Run addresses 0..18, with address 11 skipped
    for (int a = 0; a <= 18; a++) if (a != 11) push_exp(b_rom[a], 8'(a + 1));
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    check("start_busy", b_busy, 1);
    check("start_addr", b_addr, 0);

    consume("a0");
    check("a0_gap", b_valid, 0);
    consume("a1");

    // Back-pressure at address 2
    b_ready = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), b_valid, 1);
      check($sformatf("bp%0d_instr", i), b_instr, 4'b1010);
      check($sformatf("bp%0d_pc", i),    b_pc,    3);
      @(negedge clk);
    end
    b_ready = 1;
    consume("a2");
    check("bp_accept", b_valid, 0);

    for (int a = 3; a <= 9; a++) consume($sformatf("a%0d", a));

    // Skip pulsed during the handshake of address 10
    e = sb.pop_front();
    n = 0;
    while (!b_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("a10_valid", b_valid, 1);
    check("a10_instr", b_instr, e.instr);
    check("a10_pc",    b_pc,    e.pc);
    b_skip = 1;
    @(negedge clk);
    b_skip = 0;
    check("skip_n0_valid", b_valid, 0);
    check("skip_n0_pc",    b_pc,    11);
    @(negedge clk);
    check("skip_n1_valid", b_valid, 0);
    check("skip_n1_pc",    b_pc,    12);
    @(negedge clk);
    check("skip_n2_valid", b_valid, 1);

    for (int a = 12; a <= 18; a++) consume($sformatf("a%0d", a));

    // CLR-run halt after address 18
    for (int i = 0; i < 3; i++) begin
      check($sformatf("halt%0d_halted", i), b_halted, 1);
      check($sformatf("halt%0d_busy", i),   b_busy,   0);
      check($sformatf("halt%0d_valid", i),  b_valid,  0);
      check($sformatf("halt%0d_pc", i),     b_pc,     19);
      @(negedge clk);
    end

    // Restart from HALT, then reset asynchronously while address 5 is valid
    for (int a = 0; a <= 4; a++) push_exp(b_rom[a], 8'(a + 1));
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    check("restart_halted", b_halted, 0);
    check("restart_busy",   b_busy,   1);
    check("restart_pc",     b_pc,     0);
    for (int a = 0; a <= 4; a++) consume($sformatf("r%0d", a));
    b_ready = 0;
    n = 0;
    while (!b_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("r5_valid", b_valid, 1);
    check("r5_instr", b_instr, 4'b0100);
    check("r5_pc",    b_pc,    6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  b_valid,  0);
    check("arst_pc",     b_pc,     0);
    check("arst_halted", b_halted, 0);
    check("arst_instr",  b_instr,  4'b0111);
    check("arst_busy",   b_busy,   0);
    @(negedge clk);
    rst_n = 1'b1;
    b_ready = 1;
    repeat (2) @(negedge clk);
    check("post_rst_busy",  b_busy,  0);
    check("post_rst_valid", b_valid, 0);
    check("post_rst_pc",    b_pc,    0);
    push_exp(b_rom[0], 8'd1);
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    consume("p0");

    // Small instance: 4-bit wrap, halt at 15, 16 CLRs without a CLR halt
    sel = 1'b1;
    for (int a = 0; a < 16; a++) push_exp(4'b0111, 8'((a + 1) % 16));
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    for (int a = 0; a < 16; a++) consume($sformatf("w%0d", a));
    check("wrap_halted", s_halted, 1);
    check("wrap_busy",   s_busy,   0);
    check("wrap_pc",     s_pc,     0);
    check("sb_drained",  32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_fetch_sequencer.md
Name: rom_fetch_sequencer

Overview:
- Instruction-fetch controller sitting between the 4-bit-opcode program ROM and the CPU execute unit.
- Owns the program counter and drives the ROM address; the ROM is combinational, same cycle.
- Registers each fetched opcode and presents it to execute over a valid/ready handshake.
- Handles skip requests (SNZ A / SNZ S outcomes), detects end of program and halts.

Parameters:
- ADDR_WIDTH, 8: width of PC and ROM address.
- LAST_ADDR, 255: address whose issue ends the program; sequencer halts after its handshake.
- CLR_HALT_RUN, 4: number of consecutive issued CLR (4'b0111) opcodes that forces halt; 0 disables this check.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; begins or restarts execution from address 0.
- rom_addr  out  ADDR_WIDTH  ROM address (= pc, combinational from the register).
- rom_data  in  4  opcode returned by the ROM for rom_addr, same cycle.
- instr  out  4  registered opcode under issue.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  execute accepts instr this cycle.
- skip_req  in  1  single-cycle pulse: discard the next instruction after the current one.
- pc  out  ADDR_WIDTH  current fetch address.
- halted  out  1  high in HALT state.
- busy  out  1  high in FETCH or ISSUE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, instr=4'b0111, instr_valid=0, halted=0, skip_pending=0, clr_run=0. Outputs take these values immediately, not at the next edge.
- States: IDLE, FETCH, ISSUE, HALT (2-bit encoding).
- IDLE: waits; start=1 -> FETCH with pc=0.
- FETCH, no skip_pending: instr<=rom_data, fetch_addr<=pc, pc<=pc+1 (mod 2^ADDR_WIDTH; pc at all-ones wraps to 0), instr_valid<=1, -> ISSUE. Fetch-to-valid latency is 1 cycle.
- FETCH, skip_pending=1: rom_data discarded, pc<=pc+1, skip_pending<=0, stay in FETCH. Each skip costs exactly 1 cycle.
- ISSUE: instr and instr_valid are held stable until instr_ready=1.
  - On handshake: instr_valid<=0 and update clr_run: +1 if instr==4'b0111, else cleared to 0. clr_run saturates at CLR_HALT_RUN.
  - Then, in priority order:
    - HALT if fetch_addr==LAST_ADDR, or if CLR_HALT_RUN!=0 and the updated clr_run==CLR_HALT_RUN.
    - Otherwise -> FETCH.
- skip_req: sampled in FETCH and ISSUE and sets skip_pending; ignored in IDLE and HALT.
  - skip_req in the same cycle as an ISSUE handshake applies to the following fetch.
  - A second skip_req while skip_pending=1 is absorbed; no double skip.
  - If a skip_req coincides with a transition to HALT, it is dropped (skip_pending cleared).
- HALT: halted=1, instr_valid=0, pc frozen. start=1 -> FETCH with pc=0, skip_pending=0, clr_run=0, halted<=0.
- start asserted in FETCH or ISSUE is ignored; there is no mid-program restart except via rst_n.
- Reset mid-operation: an outstanding instr_valid drops immediately; no handshake completes on that edge.
- busy = (state==FETCH)|(state==ISSUE). halted and busy are never both 1.

Optional Feature:
- Macro FETCH_SINGLE_STEP_EN.
- Defined: adds input port step (1 bit). FETCH advances (capture or skip) only in a cycle where step=1; otherwise it holds state and pc. Each step pulse performs exactly one fetch or one skip. ISSUE, handshake and halt rules are unchanged.
- Undefined: no step port; FETCH advances every cycle as described above.

Test Plan:
- Reset then start, ROM 0..3 = 0000, 0001, 1010, 0010, instr_ready tied 1 -> instr sequence 0000, 0001, 1010, 0010 with valid high every other cycle, rom_addr 0, 1, 2, 3, busy=1.
- Back-pressure: hold instr_ready=0 for 5 cycles at address 2 -> instr=1010 and instr_valid=1 stable for all 5 cycles, pc=3 unchanged; accepted on the cycle ready rises.
- Skip: pulse skip_req during the handshake of address 10 (1000, SNZ A) -> address 11 is never presented; next instr is from address 12, taking 1 extra cycle.
- CLR halt: ROM 0..14 non-CLR, 15+ CLR, CLR_HALT_RUN=4 -> halted=1 after the handshake of address 18 (4th CLR); busy=0, pc=19 frozen; start restarts at address 0.
- LAST_ADDR=7, CLR_HALT_RUN=0 -> halt after address 7 is issued. Separately, ADDR_WIDTH=4, LAST_ADDR=15 -> pc wraps to 0 after the fetch of 15 and the sequencer halts.
- Async reset asserted while instr_valid=1 at address 5 -> instr_valid, pc and halted go to 0 and instr to 0111 before the next clock edge; IDLE until start.
